// File: rtl/obi_host_pipelined_driver_pkg.sv
// Shared definitions for the OBI host-side pipelined request driver:
// default bus widths, address-phase FSM encodings and sizing helpers.
package obi_host_pipelined_driver_pkg;

  localparam int XLEN = 64;
  localparam int BE_W = XLEN / 8;

  // Address-phase ownership: IDLE passes the host request straight through,
  // HOLD replays the captured request until the interconnect grants it.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } drv_state_e;

  // Bits needed to count 0..n inclusive (never less than 1).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index n entries (a single entry still gets one bit).
  function automatic int ptr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/obi_host_pipelined_driver_if.sv
// Host-side request/response signals and OBI bus signals bundled together.
// master = the driver's view, slave = the host/interconnect environment.
interface obi_host_pipelined_driver_if
  import obi_host_pipelined_driver_pkg::*;
#(
  parameter int AW = XLEN,
  parameter int DW = XLEN
);

  // host request side
  logic            rd_i;
  logic            wr_i;
  logic [DW/8-1:0] be_i;
  logic [AW-1:0]   addr_i;
  logic [DW-1:0]   wdata_i;
  logic            stall_o;
  // host response side
  logic            rsp_valid_o;
  logic            rsp_we_o;
  logic [DW-1:0]   rsp_rdata_o;
  logic            rsp_err_o;
  logic            unexp_rsp_o;
  // OBI address phase
  logic            req_o;
  logic            gnt_i;
  logic            we_o;
  logic [DW/8-1:0] be_o;
  logic [AW-1:0]   addr_o;
  logic [DW-1:0]   wdata_o;
  // OBI response phase
  logic            rvalid_i;
  logic [DW-1:0]   rdata_i;
  logic            err_i;

  modport master (
    input  rd_i, wr_i, be_i, addr_i, wdata_i,
    input  gnt_i, rvalid_i, rdata_i, err_i,
    output stall_o, rsp_valid_o, rsp_we_o, rsp_rdata_o, rsp_err_o, unexp_rsp_o,
    output req_o, we_o, be_o, addr_o, wdata_o
  );

  modport slave (
    output rd_i, wr_i, be_i, addr_i, wdata_i,
    output gnt_i, rvalid_i, rdata_i, err_i,
    input  stall_o, rsp_valid_o, rsp_we_o, rsp_rdata_o, rsp_err_o, unexp_rsp_o,
    input  req_o, we_o, be_o, addr_o, wdata_o
  );

endinterface

// File: rtl/obi_host_pipelined_driver_txn_tracker.sv
// In-order tracker of granted-but-unanswered transactions: a small circular
// FIFO with occupancy count. Head is read combinationally so the response
// path can tag rvalid in the same cycle.
module obi_txn_tracker
  import obi_host_pipelined_driver_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
)(
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic [WIDTH-1:0]              data_i,
  input  logic                          pop_i,
  output logic [WIDTH-1:0]              head_o,
  output logic [cnt_width(DEPTH)-1:0]   count_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage: each entry is written only when the write pointer selects it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                  r_mem[gi] <= '0;
      else if (push_i && (r_wr_ptr == PW'(gi)))     r_mem[gi] <= data_i;
    end
  end

  // Pointers wrap modulo DEPTH; count tracks push minus pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      if (pop_i)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;
  assign full_o  = (r_count == DEPTH_CNT);
  assign empty_o = (r_count == '0);

endmodule

// File: rtl/obi_host_pipelined_driver.sv
// OBI host-side pipelined request driver. Passes host requests onto OBI,
// holds them stable until granted, and returns in-order responses tagged
// read/write with zero latency.
module obi_host_pipelined_driver
  import obi_host_pipelined_driver_pkg::*;
#(
  parameter int AW              = XLEN,
  parameter int DW              = XLEN,
  parameter int MAX_OUTSTANDING = 2,
  parameter int BLOCKING_RD     = 0
)(
  input  logic                         clk_i,
  input  logic                         rst_ni,
  obi_host_pipelined_driver_if.master  bus
);

  localparam int CW = cnt_width(MAX_OUTSTANDING);

  drv_state_e      r_state;
  drv_state_e      w_state_next;
  logic            r_we;
  logic [DW/8-1:0] r_be;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_unexp;
  logic [CW-1:0]   r_rd_cnt;

  logic            w_host_req;
  logic            w_can_issue;
  logic            w_req;
  logic            w_we;
  logic [DW/8-1:0] w_be;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;
  logic            w_stall_base;
  logic            w_capture;
  logic            w_push;
  logic            w_pop;
  logic            w_head_we;
  logic [CW-1:0]   w_cnt;
  logic            w_full;
  logic            w_empty;
  logic            w_rd_push;
  logic            w_rd_pop;
  logic [CW-1:0]   w_rd_left;
  logic            w_rd_block;

  assign w_host_req  = bus.rd_i | bus.wr_i;
  // A response arriving this cycle frees a slot for a same-cycle issue.
  assign w_can_issue = ~w_full | bus.rvalid_i;
  assign w_push      = w_req & bus.gnt_i;
  assign w_pop       = bus.rvalid_i & ~w_empty;

  obi_txn_tracker #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_tracker (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (w_we),
    .pop_i   (w_pop),
    .head_o  (w_head_we),
    .count_o (w_cnt),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Address-phase FSM: pass-through in IDLE, replay from hold regs in HOLD.
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_stall_base = 1'b0;
    w_capture    = 1'b0;
    w_we         = bus.wr_i;
    w_be         = bus.be_i;
    w_addr       = bus.addr_i;
    w_wdata      = bus.wdata_i;
    case (r_state)
      ST_IDLE: begin
        if (w_host_req) begin
          if (w_can_issue) begin
            w_req = 1'b1;
            if (!bus.gnt_i) begin
              w_capture    = 1'b1;
              w_stall_base = 1'b1;
              w_state_next = ST_HOLD;
            end
          end else begin
            w_stall_base = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        w_req   = 1'b1;
        w_we    = r_we;
        w_be    = r_be;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        if (bus.gnt_i) w_state_next = ST_IDLE;
        else           w_stall_base = 1'b1;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Hold registers capture the ungranted request on the IDLE->HOLD step.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_capture) begin
      r_we    <= bus.wr_i;
      r_be    <= bus.be_i;
      r_addr  <= bus.addr_i;
      r_wdata <= bus.wdata_i;
    end
  end

  // Outstanding-read count feeding the optional blocking-read stall.
  assign w_rd_push = w_push & ~w_we;
  assign w_rd_pop  = w_pop & ~w_head_we;
  assign w_rd_left = r_rd_cnt - CW'(w_rd_pop);
  assign w_rd_block = (BLOCKING_RD != 0) && (w_rd_left != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_rd_cnt <= '0;
    else         r_rd_cnt <= r_rd_cnt + CW'(w_rd_push) - CW'(w_rd_pop);
  end

  // Sticky flag for a response that matches no outstanding transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                             r_unexp <= 1'b0;
    else if (bus.rvalid_i && (w_cnt == '0))  r_unexp <= 1'b1;
  end

  assign bus.req_o       = w_req;
  assign bus.we_o        = w_we;
  assign bus.be_o        = w_be;
  assign bus.addr_o      = w_addr;
  assign bus.wdata_o     = w_wdata;
  assign bus.stall_o     = w_stall_base | w_rd_block;
  assign bus.rsp_valid_o = w_pop;
  assign bus.rsp_we_o    = w_head_we;
  assign bus.rsp_rdata_o = bus.rdata_i;
  assign bus.rsp_err_o   = bus.err_i;
  assign bus.unexp_rsp_o = r_unexp;

endmodule

// File: tb/tb_obi_host_pipelined_driver.sv
// Directed bench: dut_a (non-blocking reads) and dut_b (blocking reads),
// both with MAX_OUTSTANDING=2. Inputs change 1ns after posedge; outputs
// are checked 1ns later.
module tb_obi_host_pipelined_driver;

  logic clk = 1'b0;
  logic rst_na = 1'b0;
  logic rst_nb = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  obi_host_pipelined_driver_if #(.AW(64), .DW(64)) ifa ();
  obi_host_pipelined_driver_if #(.AW(64), .DW(64)) ifb ();

  obi_host_pipelined_driver #(.AW(64), .DW(64), .MAX_OUTSTANDING(2), .BLOCKING_RD(0))
    dut_a (.clk_i(clk), .rst_ni(rst_na), .bus(ifa));
  obi_host_pipelined_driver #(.AW(64), .DW(64), .MAX_OUTSTANDING(2), .BLOCKING_RD(1))
    dut_b (.clk_i(clk), .rst_ni(rst_nb), .bus(ifb));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic clr_a();
    ifa.rd_i = 0; ifa.wr_i = 0; ifa.be_i = '0; ifa.addr_i = '0; ifa.wdata_i = '0;
    ifa.gnt_i = 0; ifa.rvalid_i = 0; ifa.rdata_i = '0; ifa.err_i = 0;
  endtask

  task automatic clr_b();
    ifb.rd_i = 0; ifb.wr_i = 0; ifb.be_i = '0; ifb.addr_i = '0; ifb.wdata_i = '0;
    ifb.gnt_i = 0; ifb.rvalid_i = 0; ifb.rdata_i = '0; ifb.err_i = 0;
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_a();
    clr_b();
    #2;
    // reset state
    check("rst_req", ifa.req_o, 0);
    check("rst_stall", ifa.stall_o, 0);
    check("rst_rsp_valid", ifa.rsp_valid_o, 0);
    check("rst_unexp", ifa.unexp_rsp_o, 0);
    cyc(); cyc();
    rst_na = 1'b1;
    rst_nb = 1'b1;
    cyc();

    // T1: read granted at once, response two cycles later
    ifa.rd_i = 1; ifa.addr_i = 64'h100; ifa.be_i = 8'hFF; ifa.gnt_i = 1; #1;
    $display("txn T1 read issue");
    check("t1_req", ifa.req_o, 1);
    check("t1_stall", ifa.stall_o, 0);
    check("t1_addr", ifa.addr_o, 64'h100);
    check("t1_we", ifa.we_o, 0);
    cyc(); clr_a();
    cyc();
    ifa.rvalid_i = 1; ifa.rdata_i = 64'hDEADBEEF_00000001; #1;
    $display("txn T1 read response");
    check("t1_rsp_valid", ifa.rsp_valid_o, 1);
    check("t1_rsp_we", ifa.rsp_we_o, 0);
    check("t1_rsp_rdata", ifa.rsp_rdata_o, 64'hDEADBEEF_00000001);
    cyc(); clr_a();

    // T2: write held for three ungranted cycles while host changes address
    ifa.wr_i = 1; ifa.addr_i = 64'h1000; ifa.wdata_i = 64'h55; ifa.be_i = 8'h0F; #1;
    $display("txn T2 write issue (no grant)");
    check("t2_c0_stall", ifa.stall_o, 1);
    check("t2_c0_req", ifa.req_o, 1);
    for (int i = 1; i < 3; i++) begin
      cyc();
      ifa.addr_i = 64'h2000; ifa.wdata_i = 64'h77; ifa.be_i = 8'hF0; #1;
      check("t2_hold_addr", ifa.addr_o, 64'h1000);
      check("t2_hold_we", ifa.we_o, 1);
      check("t2_hold_stall", ifa.stall_o, 1);
    end
    cyc();
    ifa.gnt_i = 1; #1;
    $display("txn T2 write granted");
    check("t2_gnt_stall", ifa.stall_o, 0);
    check("t2_gnt_addr", ifa.addr_o, 64'h1000);
    check("t2_gnt_wdata", ifa.wdata_o, 64'h55);
    check("t2_gnt_be", ifa.be_o, 64'h0F);
    cyc(); clr_a();
    ifa.rvalid_i = 1; #1;
    check("t2_rsp_valid", ifa.rsp_valid_o, 1);
    check("t2_rsp_we", ifa.rsp_we_o, 1);
    cyc(); clr_a();
    // a second push would leave a stale entry: this rvalid must be unmatched
    ifa.rvalid_i = 1; #1;
    check("t2_single_push", ifa.rsp_valid_o, 0);
    cyc(); clr_a();
    // clear the sticky flag before continuing
    rst_na = 1'b0; #1;
    check("t2_unexp_rst", ifa.unexp_rsp_o, 0);
    cyc(); rst_na = 1'b1;
    cyc();

    // T3: three back-to-back reads, always granted, limit of two
    ifa.rd_i = 1; ifa.gnt_i = 1; ifa.addr_i = 64'h10; #1;
    check("t3_r0_stall", ifa.stall_o, 0);
    cyc(); ifa.addr_i = 64'h18; #1;
    check("t3_r1_stall", ifa.stall_o, 0);
    cyc(); ifa.addr_i = 64'h20; #1;
    $display("txn T3 third read blocked");
    check("t3_r2_req", ifa.req_o, 0);
    check("t3_r2_stall", ifa.stall_o, 1);
    cyc(); ifa.rvalid_i = 1; ifa.rdata_i = 64'h1; #1;
    $display("txn T3 third read issued with response");
    check("t3_r2b_req", ifa.req_o, 1);
    check("t3_r2b_stall", ifa.stall_o, 0);
    check("t3_rsp_valid", ifa.rsp_valid_o, 1);
    cyc(); ifa.rvalid_i = 0; ifa.addr_i = 64'h28; #1;
    check("t3_full_req", ifa.req_o, 0);
    check("t3_full_stall", ifa.stall_o, 1);
    cyc(); clr_a();
    ifa.rvalid_i = 1; #1;
    check("t3_drain0", ifa.rsp_valid_o, 1);
    cyc();
    check("t3_drain1", ifa.rsp_valid_o, 1);
    cyc(); clr_a();

    // T4: write then read, in-order responses, error on the second
    ifa.wr_i = 1; ifa.gnt_i = 1; ifa.addr_i = 64'h40; #1;
    cyc(); ifa.wr_i = 0; ifa.rd_i = 1; ifa.addr_i = 64'h48; #1;
    check("t4_rd_stall", ifa.stall_o, 0);
    cyc(); clr_a();
    ifa.rvalid_i = 1; #1;
    $display("txn T4 write response");
    check("t4_rsp0_we", ifa.rsp_we_o, 1);
    check("t4_rsp0_err", ifa.rsp_err_o, 0);
    cyc(); ifa.err_i = 1; ifa.rdata_i = 64'hABCD; #1;
    $display("txn T4 read response with error");
    check("t4_rsp1_we", ifa.rsp_we_o, 0);
    check("t4_rsp1_err", ifa.rsp_err_o, 1);
    check("t4_rsp1_rdata", ifa.rsp_rdata_o, 64'hABCD);
    cyc(); clr_a();

    // T5: unexpected response is flagged and sticky until reset
    ifa.rvalid_i = 1; #1;
    $display("txn T5 unexpected response");
    check("t5_rsp_valid", ifa.rsp_valid_o, 0);
    cyc(); clr_a(); #1;
    check("t5_unexp_set", ifa.unexp_rsp_o, 1);
    cyc();
    check("t5_unexp_sticky", ifa.unexp_rsp_o, 1);
    rst_na = 1'b0; #1;
    check("t5_unexp_cleared", ifa.unexp_rsp_o, 0);
    cyc(); rst_na = 1'b1;

    // T6: blocking reads on dut_b
    cyc();
    ifb.rd_i = 1; ifb.gnt_i = 1; ifb.addr_i = 64'h80; #1;
    $display("txn T6 blocking read issue");
    check("t6_issue_stall", ifb.stall_o, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); clr_b(); #1;
      check("t6_wait_stall", ifb.stall_o, 1);
    end
    cyc(); ifb.rvalid_i = 1; ifb.rdata_i = 64'h99; #1;
    $display("txn T6 blocking read response");
    check("t6_rsp_stall", ifb.stall_o, 0);
    check("t6_rsp_valid", ifb.rsp_valid_o, 1);
    cyc(); clr_b(); #1;
    check("t6_after_stall", ifb.stall_o, 0);

    // T7: reset asserted while dut_b is in HOLD
    cyc();
    ifb.wr_i = 1; ifb.addr_i = 64'h3000; #1;
    check("t7_hold_stall", ifb.stall_o, 1);
    cyc(); ifb.wr_i = 0; ifb.addr_i = 64'h4000; #1;
    check("t7_hold_req", ifb.req_o, 1);
    check("t7_hold_addr", ifb.addr_o, 64'h3000);
    rst_nb = 1'b0; #1;
    $display("txn T7 reset in HOLD");
    check("t7_rst_req", ifb.req_o, 0);
    check("t7_rst_stall", ifb.stall_o, 0);
    cyc(); rst_nb = 1'b1;
    cyc(); ifb.rvalid_i = 1; #1;
    check("t7_cnt_zero", ifb.rsp_valid_o, 0);
    cyc(); clr_b(); #1;
    check("t7_unexp", ifb.unexp_rsp_o, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/obi_host_pipelined_driver.md
Name: obi_host_pipelined_driver

Overview:
Parametrised OBI host-side request driver for Lucid64 fetch/LSU ports. It supports up to MAX_OUTSTANDING in-flight transactions. It owns each address-phase request until granted, replaying it from a hold register if the host pipeline moves on. It tracks outstanding transactions in order so every response is returned to the host tagged read/write. It sits between a core memory stage and an OBI interconnect port.

Parameters:
AW, 64, address width
DW, 64, data width; BE width = DW/8
MAX_OUTSTANDING, 2, max granted-but-unanswered transactions (>=1)
BLOCKING_RD, 0, 1 = hold stall_o while any read is outstanding and unanswered

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
rd_i  in  1  host read request
wr_i  in  1  host write request (rd_i&wr_i illegal)
be_i  in  DW/8  host byte enables
addr_i  in  AW  host address
wdata_i  in  DW  host write data
stall_o  out  1  host request not accepted this cycle; host must not advance
rsp_valid_o  out  1  response to host
rsp_we_o  out  1  response belongs to a write
rsp_rdata_o  out  DW  read data
rsp_err_o  out  1  bus error
unexp_rsp_o  out  1  sticky: rvalid_i seen with no outstanding transaction
req_o  out  1  OBI request
gnt_i  in  1  OBI grant
we_o  out  1  OBI write enable
be_o  out  DW/8  OBI byte enables
addr_o  out  AW  OBI address
wdata_o  out  DW  OBI write data
rvalid_i  in  1  OBI response valid
rdata_i  in  DW  OBI read data
err_i  in  1  OBI error

Behaviour:
- Reset (async assert, sync deassert by use): state IDLE, cnt=0, tracker empty, hold regs 0, unexp_rsp_o=0. req_o=0 unless host requests.
- host_req = rd_i|wr_i. can_issue = (cnt<MAX_OUTSTANDING) | rvalid_i.
- IDLE, host_req & can_issue: req_o=1, address-phase outputs = host inputs (combinational).
  - gnt_i=1: accepted, stall_o=0.
  - gnt_i=0: capture we/be/addr/wdata into hold regs, go HOLD, stall_o=1.
- IDLE, host_req & !can_issue: req_o=0, stall_o=1, no capture. Host keeps presenting the request.
- IDLE, !host_req: req_o=0, stall_o=0.
- HOLD: req_o=1, outputs from hold regs, host inputs ignored. Outputs are stable until grant (OBI rule).
  - gnt_i=1: stall_o=0 (the held transaction counts as accepted), next state IDLE.
  - gnt_i=0: stall_o=1.
  - No new request may issue in the grant cycle.
- BLOCKING_RD=1: stall_o additionally forced to 1 while rd_outstanding>0 and the current cycle is not that read's rvalid_i. Issue is unaffected.
- push = req_o & gnt_i (we bit into tracker). pop = rvalid_i & cnt>0.
- cnt_next = cnt + push - pop. Simultaneous push/pop at cnt==MAX is legal and leaves cnt unchanged.
- Response path is zero latency: rsp_valid_o=rvalid_i&cnt>0, rsp_rdata_o=rdata_i, rsp_err_o=err_i, rsp_we_o=tracker head.
- rvalid_i with cnt==0: no pop, no rsp_valid_o, unexp_rsp_o set until reset.
- Tracker: circular FIFO, depth MAX_OUTSTANDING, pointers wrap modulo depth. Never overflows because issue is gated by can_issue.
- Counter width: $clog2(MAX_OUTSTANDING+1).
- Reset mid-HOLD or with responses pending: all state is dropped. Interconnect must be reset together.

Decomposition:
- Lucid64.vh: OBI width defaults (XLEN=64, BE width) and the FSM state encodings IDLE/HOLD.
- One sub-module: obi_txn_tracker, parametrised depth/width FIFO with count, holding per-transaction we bit, full/empty outputs.

Test Plan:
- Read, gnt_i same cycle, rvalid_i with rdata=0xDEADBEEF_00000001 two cycles later -> stall_o=0 at issue; rsp_valid_o=1, rsp_we_o=0, rdata matches; cnt returns to 0.
- Write addr 0x1000, gnt_i low 3 cycles while host changes addr_i to 0x2000 -> addr_o=0x1000, we_o=1 held; stall_o=1 for 3 cycles, 0 in the grant cycle; single push.
- MAX_OUTSTANDING=2: three back-to-back reads, always granted, no rvalid -> third read gets req_o=0, stall_o=1. rvalid_i in that cycle -> third read issues; cnt stays 2.
- Interleaved write then read, responses in order -> rsp_we_o = 1 then 0; err_i=1 on the second response -> rsp_err_o=1.
- rvalid_i with cnt=0 -> rsp_valid_o=0, unexp_rsp_o=1 persists until rst_ni=0.
- BLOCKING_RD=1: read granted, rvalid after 4 cycles -> stall_o=1 for 4 cycles, 0 in the rvalid cycle. Assert rst_ni=0 while in HOLD -> req_o drops immediately, cnt=0.
